tod_controller: RTL and testbench

Time-of-day controller for the alarm clock. It consumes the one-cycle `sec_inc` tick from the seconds counter and maintains hours/minutes/seconds. A button-driven set-mode state machine adjusts the time and alarm settings and holds the seconds counter cleared while time is being set. It compares time against the alarm setting and drives a self-timing `alarm_ring` output toward the display/buzzer logic.

---
 rtl/tod_controller.sv | 142 ++++++++++++++
 tb/tb_tod_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tod_controller.sv
// Time-of-day controller: keeps hh:mm:ss from the 1 Hz tick, runs the button
// driven set-mode sequencer, and rings a self-timing alarm on a time match.
module tod_controller #(
  parameter int unsigned RING_SECS     = 60,
  parameter int unsigned ALARM_HR_RST  = 6,
  parameter int unsigned ALARM_MIN_RST = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sec_inc,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       alarm_en,
  output logic       sec_clr,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [2:0] mode,
  output logic       alarm_ring
);

  localparam int unsigned HR_W  = 5;
  localparam int unsigned MS_W  = 6;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    SET_HR     = 3'd1,
    SET_MIN    = 3'd2,
    SET_AL_HR  = 3'd3,
    SET_AL_MIN = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [HR_W-1:0]   hr_q, hr_d, al_hr_q, al_hr_d, hr_nx;
  logic [MS_W-1:0]   min_q, min_d, sec_q, sec_d, al_min_q, al_min_d, min_nx, sec_nx;
  logic              ring_q, ring_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              press, adv_en, advance, trig, dismiss, sec_wrap, min_wrap;

  always_comb begin
    state_d  = state_q;
    hr_d     = hr_q;
    min_d    = min_q;
    sec_d    = sec_q;
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    ring_d   = ring_q;
    cnt_d    = cnt_q;

    press    = btn_mode | btn_up;
    // A RUN->SET_HR transition takes priority over a coincident tick.
    adv_en   = (state_q inside {RUN, SET_AL_HR, SET_AL_MIN}) &&
               !((state_q == RUN) && btn_mode && !ring_q);
    advance  = adv_en && sec_inc;

    sec_wrap = (sec_q == 6'd59);
    min_wrap = sec_wrap && (min_q == 6'd59);
    sec_nx   = sec_wrap ? '0 : sec_q + 6'd1;
    min_nx   = !sec_wrap ? min_q : ((min_q == 6'd59) ? '0 : min_q + 6'd1);
    hr_nx    = !min_wrap ? hr_q : ((hr_q == 5'd23) ? '0 : hr_q + 5'd1);

    // Compare against the alarm value as it stands before any btn_up this cycle.
    trig     = advance && alarm_en && sec_wrap &&
               (min_nx == al_min_q) && (hr_nx == al_hr_q);
    dismiss  = press && (ring_q || trig);

    if (advance) begin
      hr_d  = hr_nx;
      min_d = min_nx;
      sec_d = sec_nx;
    end

    if (!dismiss && btn_mode) begin
      unique case (state_q)
        RUN:        begin state_d = SET_HR; sec_d = '0; end
        SET_HR:     state_d = SET_MIN;
        SET_MIN:    state_d = SET_AL_HR;
        SET_AL_HR:  state_d = SET_AL_MIN;
        default:    state_d = RUN;
      endcase
    end else if (!dismiss && btn_up) begin
      unique case (state_q)
        SET_HR:     hr_d     = (hr_q == 5'd23)     ? '0 : hr_q + 5'd1;
        SET_MIN:    min_d    = (min_q == 6'd59)    ? '0 : min_q + 6'd1;
        SET_AL_HR:  al_hr_d  = (al_hr_q == 5'd23)  ? '0 : al_hr_q + 5'd1;
        SET_AL_MIN: al_min_d = (al_min_q == 6'd59) ? '0 : al_min_q + 6'd1;
        default:    ;
      endcase
    end

    if ((state_q == SET_HR) || (state_q == SET_MIN)) sec_d = '0;

    // Ring timer: auto-stop, retrigger load, then dismiss/disarm override.
    if (ring_q && sec_inc) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) ring_d = 1'b0;
    end
    if (trig) begin
      ring_d = 1'b1;
      cnt_d  = CNT_W'(RING_SECS);
    end
    if (dismiss || !alarm_en) begin
      ring_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      hr_q     <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      al_hr_q  <= HR_W'(ALARM_HR_RST);
      al_min_q <= MS_W'(ALARM_MIN_RST);
      ring_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hr_q     <= hr_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      al_hr_q  <= al_hr_d;
      al_min_q <= al_min_d;
      ring_q   <= ring_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sec_clr       = (state_q == SET_HR) || (state_q == SET_MIN);
  assign hours         = hr_q;
  assign minutes       = min_q;
  assign seconds       = sec_q;
  assign alarm_hours   = al_hr_q;
  assign alarm_minutes = al_min_q;
  assign mode          = state_q;
  assign alarm_ring    = ring_q;

endmodule

// File: tb/tb_tod_controller.sv
// Bench for tod_controller: vector table, directed corner sequences and a
// randomized run, all cross-checked against a seconds-of-day reference model.
module tb_tod_controller;

  localparam int RING = 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       sec_inc = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, alarm_en = 1'b0;
  logic       sec_clr, alarm_ring;
  logic [4:0] hours, alarm_hours;
  logic [5:0] minutes, seconds, alarm_minutes;
  logic [2:0] mode;

  always #5 clk = ~clk;

  tod_controller #(
    .RING_SECS(RING), .ALARM_HR_RST(6), .ALARM_MIN_RST(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sec_inc(sec_inc), .btn_mode(btn_mode),
    .btn_up(btn_up), .alarm_en(alarm_en), .sec_clr(sec_clr), .hours(hours),
    .minutes(minutes), .seconds(seconds), .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes), .mode(mode), .alarm_ring(alarm_ring)
  );

  int n_checks = 0, n_errors = 0;

  // Reference state: time as seconds of day, alarm as minutes of day.
  int t, al, m_mode, m_rem;
  bit m_ring;

  typedef struct {
    bit sm, bm, bu;
    int hr, mi, se, md, ahr, amin;
    bit ring, clr;
  } vec_t;
  vec_t vt[13];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; al = 6 * 60; m_mode = 0; m_ring = 0; m_rem = 0;
  endtask

  task automatic model_step(bit sm, bit bm, bit bu, bit en);
    bit press, adv_ok, trig, dismiss;
    int h, mi, s;
    press   = bm | bu;
    adv_ok  = (m_mode == 0 || m_mode == 3 || m_mode == 4) && !(m_mode == 0 && bm && !m_ring);
    trig    = adv_ok && sm && en && (((t + 1) % 86400) == al * 60);
    dismiss = press && (m_ring || trig);
    if (m_ring && sm) begin
      m_rem--;
      if (m_rem == 0) m_ring = 0;
    end
    if (trig) begin m_ring = 1; m_rem = RING; end
    if (dismiss || !en) m_ring = 0;
    if (adv_ok && sm) t = (t + 1) % 86400;
    if (!dismiss && bm) begin
      if (m_mode == 0) t = t - (t % 60);
      m_mode = (m_mode + 1) % 5;
    end else if (!dismiss && bu) begin
      h = t / 3600; mi = (t / 60) % 60; s = t % 60;
      case (m_mode)
        1: h = (h + 1) % 24;
        2: mi = (mi + 1) % 60;
        3: al = (((al / 60) + 1) % 24) * 60 + (al % 60);
        4: al = (al / 60) * 60 + ((al % 60) + 1) % 60;
        default: ;
      endcase
      t = h * 3600 + mi * 60 + s;
    end
  endtask

  task automatic check_model();
    int eh, em, es, eah, eam, ec;
    eh = t / 3600; em = (t / 60) % 60; es = t % 60;
    eah = al / 60; eam = al % 60;
    ec = (m_mode == 1 || m_mode == 2) ? 1 : 0;
    n_checks++;
    if (hours !== 5'(eh) || minutes !== 6'(em) || seconds !== 6'(es) ||
        alarm_hours !== 5'(eah) || alarm_minutes !== 6'(eam) || mode !== 3'(m_mode) ||
        alarm_ring !== m_ring || sec_clr !== ec[0]) begin
      n_errors++;
      $display("FAIL model: got %0d:%0d:%0d al %0d:%0d mode %0d ring %0d clr %0d, expected %0d:%0d:%0d al %0d:%0d mode %0d ring %0d clr %0d",
               hours, minutes, seconds, alarm_hours, alarm_minutes, mode, alarm_ring, sec_clr,
               eh, em, es, eah, eam, m_mode, m_ring, ec);
    end
  endtask

  // One clock cycle: inputs stable across the edge, outputs sampled 1 time unit after it.
  task automatic cyc(bit sm, bit bm, bit bu, bit en);
    sec_inc = sm; btn_mode = bm; btn_up = bu; alarm_en = en;
    @(posedge clk); #1;
    sec_inc = 0; btn_mode = 0; btn_up = 0;
    model_step(sm, bm, bu, en);
    check_model();
  endtask

  task automatic do_reset();
    sec_inc = 0; btn_mode = 0; btn_up = 0;
    reset_n = 1'b0;
    #2;
    model_reset();
    check_model();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, " hours"}, int'(hours), 0);
    check({tag, " minutes"}, int'(minutes), 0);
    check({tag, " seconds"}, int'(seconds), 0);
    check({tag, " alarm_hours"}, int'(alarm_hours), 6);
    check({tag, " alarm_minutes"}, int'(alarm_minutes), 0);
    check({tag, " mode"}, int'(mode), 0);
    check({tag, " alarm_ring"}, int'(alarm_ring), 0);
    check({tag, " sec_clr"}, int'(sec_clr), 0);
  endtask

  // Reset, then program the alarm to 00:02; optionally return to RUN.
  task automatic set_alarm_0002(bit to_run);
    do_reset();
    repeat (3) cyc(0, 1, 0, 1);
    repeat (18) cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 1);
    repeat (2) cyc(0, 0, 1, 1);
    if (to_run) cyc(0, 1, 0, 1);
    check("alarm setup hours", int'(alarm_hours), 0);
    check("alarm setup minutes", int'(alarm_minutes), 2);
  endtask

  initial begin
    bit en;
    vt[0]  = '{1, 0, 0, 0, 0, 1, 0, 6, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 0, 0, 2, 0, 6, 0, 0, 0};
    vt[2]  = '{0, 0, 1, 0, 0, 2, 0, 6, 0, 0, 0};
    vt[3]  = '{1, 1, 0, 0, 0, 0, 1, 6, 0, 0, 1};
    vt[4]  = '{0, 0, 1, 1, 0, 0, 1, 6, 0, 0, 1};
    vt[5]  = '{1, 0, 1, 2, 0, 0, 1, 6, 0, 0, 1};
    vt[6]  = '{0, 1, 1, 2, 0, 0, 2, 6, 0, 0, 1};
    vt[7]  = '{0, 0, 1, 2, 1, 0, 2, 6, 0, 0, 1};
    vt[8]  = '{0, 1, 0, 2, 1, 0, 3, 6, 0, 0, 0};
    vt[9]  = '{1, 0, 1, 2, 1, 1, 3, 7, 0, 0, 0};
    vt[10] = '{0, 1, 0, 2, 1, 1, 4, 7, 0, 0, 0};
    vt[11] = '{0, 0, 1, 2, 1, 1, 4, 7, 1, 0, 0};
    vt[12] = '{1, 1, 0, 2, 1, 2, 0, 7, 1, 0, 0};

    #1;
    do_reset();
    check_reset_vals("reset");

    for (int i = 0; i < 13; i++) begin
      cyc(vt[i].sm, vt[i].bm, vt[i].bu, 1'b1);
      check($sformatf("vec%0d hours", i), int'(hours), vt[i].hr);
      check($sformatf("vec%0d minutes", i), int'(minutes), vt[i].mi);
      check($sformatf("vec%0d seconds", i), int'(seconds), vt[i].se);
      check($sformatf("vec%0d mode", i), int'(mode), vt[i].md);
      check($sformatf("vec%0d alarm_hours", i), int'(alarm_hours), vt[i].ahr);
      check($sformatf("vec%0d alarm_minutes", i), int'(alarm_minutes), vt[i].amin);
      check($sformatf("vec%0d alarm_ring", i), int'(alarm_ring), int'(vt[i].ring));
      check($sformatf("vec%0d sec_clr", i), int'(sec_clr), int'(vt[i].clr));
    end

    // 3661 back-to-back ticks from midnight.
    do_reset();
    repeat (3661) cyc(1, 0, 0, 1);
    check("count hours", int'(hours), 1);
    check("count minutes", int'(minutes), 1);
    check("count seconds", int'(seconds), 1);

    // Preload 23:59 via set mode, then spaced ticks across midnight.
    do_reset();
    cyc(0, 1, 0, 0);
    repeat (23) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    repeat (59) cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 1, 0, 0);
    repeat (58) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
    check("pre-wrap hours", int'(hours), 23);
    check("pre-wrap minutes", int'(minutes), 59);
    check("pre-wrap seconds", int'(seconds), 58);
    repeat (2) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
    check("wrap hours", int'(hours), 0);
    check("wrap minutes", int'(minutes), 0);
    check("wrap seconds", int'(seconds), 0);

    // Hour setting wraps and freezes the clock.
    do_reset();
    cyc(0, 1, 0, 1);
    repeat (25) cyc(0, 0, 1, 1);
    check("set_hr mode", int'(mode), 1);
    check("set_hr sec_clr", int'(sec_clr), 1);
    check("set_hr hours", int'(hours), 1);
    check("set_hr seconds", int'(seconds), 0);
    repeat (5) cyc(1, 0, 0, 1);
    check("frozen hours", int'(hours), 1);
    check("frozen minutes", int'(minutes), 0);
    check("frozen seconds", int'(seconds), 0);

    // Alarm rises at 00:02:00 and self-clears after RING ticks.
    set_alarm_0002(1);
    repeat (119) cyc(1, 0, 0, 1);
    check("pre-alarm ring", int'(alarm_ring), 0);
    cyc(1, 0, 0, 1);
    check("alarm ring rise", int'(alarm_ring), 1);
    check("alarm minutes", int'(minutes), 2);
    repeat (RING - 1) cyc(1, 0, 0, 1);
    check("ring before stop", int'(alarm_ring), 1);
    cyc(1, 0, 0, 1);
    check("ring auto-stop", int'(alarm_ring), 0);
    check("auto-stop minutes", int'(minutes), 3);
    check("auto-stop seconds", int'(seconds), 0);

    // Dismiss by mode press: press consumed.
    set_alarm_0002(1);
    repeat (120) cyc(1, 0, 0, 1);
    check("ring before dismiss", int'(alarm_ring), 1);
    cyc(0, 1, 0, 1);
    check("dismiss ring", int'(alarm_ring), 0);
    check("dismiss mode", int'(mode), 0);

    // Dismiss by disarming.
    set_alarm_0002(1);
    repeat (120) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("disarm ring", int'(alarm_ring), 0);
    check("disarm mode", int'(mode), 0);

    // Trigger while in SET_AL_MIN, then asynchronous reset mid-ring.
    set_alarm_0002(0);
    repeat (120) cyc(1, 0, 0, 1);
    check("al_min ring", int'(alarm_ring), 1);
    check("al_min mode", int'(mode), 4);
    #2;
    do_reset();
    check_reset_vals("async reset");

    // Randomized traffic against the reference model.
    set_alarm_0002(1);
    en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) en = ~en;
      cyc(($urandom_range(2) != 0), ($urandom_range(49) == 0), ($urandom_range(19) == 0), en);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
